// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - priority interrupt controller with ack handshake and in-service tracking
// Optional nesting of higher-priority sources is enabled by defining INT_CTRL_NESTING_EN.
module interrupt_controller #(
    parameter int N     = 8,
    parameter int VEC_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     int_request,
    output logic [N-1:0]     int_handled,
    input  logic [N-1:0]     int_mask,
    output logic             irq,
    output logic [VEC_W-1:0] irq_vector,
    input  logic             cpu_ack,
    input  logic             cpu_eoi,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             irq_q, irq_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [N-1:0]     handled_q, handled_d;
    logic [N-1:0]     in_service_q, in_service_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     is_lowest;
    logic [N-1:0]     allowed;
    logic [N-1:0]     eligible;
    logic [N-1:0]     ack_set;
    logic [N-1:0]     eoi_clear;
    logic [VEC_W-1:0] top_vec;

    // Lowest set in-service bit isolates both the EOI target and the preemption threshold.
    always_comb begin
        is_lowest = in_service_q & (~in_service_q + N'(1));
`ifdef INT_CTRL_NESTING_EN
        allowed = (in_service_q == '0) ? '1 : (is_lowest - N'(1));
`else
        allowed = (in_service_q == '0) ? '1 : '0;
`endif
        eligible  = int_request & ~int_mask & ~in_service_q & allowed;
        eoi_clear = cpu_eoi ? is_lowest : '0;
        top_vec   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                top_vec = VEC_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_d     = irq_q;
        vec_d     = vec_q;
        handled_d = '0;
        ack_set   = '0;
        case (state_q)
            ST_IDLE: begin
                irq_d = 1'b0;
                if (eligible != '0) begin
                    state_d = ST_PENDING;
                    irq_d   = 1'b1;
                    vec_d   = top_vec;
                end
            end
            ST_PENDING: begin
                if (eligible == '0) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end else if (cpu_ack) begin
                    // Acknowledge the vector the CPU saw, not a freshly re-evaluated one.
                    state_d   = ST_ACK;
                    irq_d     = 1'b0;
                    handled_d = N'(1) << vec_q;
                    ack_set   = N'(1) << vec_q;
                end else begin
                    vec_d = top_vec;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
        in_service_d = (in_service_q & ~eoi_clear) | ack_set;
        busy_d       = |in_service_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            vec_q        <= '0;
            handled_q    <= '0;
            in_service_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            vec_q        <= vec_d;
            handled_q    <= handled_d;
            in_service_q <= in_service_d;
            busy_q       <= busy_d;
        end
    end

    assign irq         = irq_q;
    assign irq_vector  = vec_q;
    assign int_handled = handled_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed and random checks of interrupt_controller against a behavioural model
module tb_interrupt_controller;
    localparam int N     = 8;
    localparam int VEC_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     int_request;
    logic [N-1:0]     int_handled;
    logic [N-1:0]     int_mask;
    logic             irq;
    logic [VEC_W-1:0] irq_vector;
    logic             cpu_ack;
    logic             cpu_eoi;
    logic             busy;

    int total = 0;
    int bad   = 0;

    int   m_state;
    logic m_irq;
    int   m_vec;
    int   m_hand;
    bit   m_is [N];

    always #5 clk = ~clk;

    interrupt_controller #(.N(N), .VEC_W(VEC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .int_request (int_request),
        .int_handled (int_handled),
        .int_mask    (int_mask),
        .irq         (irq),
        .irq_vector  (irq_vector),
        .cpu_ack     (cpu_ack),
        .cpu_eoi     (cpu_eoi),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_in_service();
        for (int i = 0; i < N; i++) begin
            if (m_is[i]) return i;
        end
        return -1;
    endfunction

    function automatic int pick();
        int lim;
        lim = lowest_in_service();
        if (lim < 0) lim = N;
`ifndef INT_CTRL_NESTING_EN
        if (lim != N) return -1;
`endif
        for (int i = 0; i < lim; i++) begin
            if (int_request[i] && !int_mask[i] && !m_is[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int p;
        int low;
        p   = pick();
        low = lowest_in_service();
        if (!rst_n) begin
            m_state = 0;
            m_irq   = 1'b0;
            m_vec   = 0;
            m_hand  = -1;
            for (int i = 0; i < N; i++) m_is[i] = 1'b0;
            return;
        end
        m_hand = -1;
        if (cpu_eoi && low >= 0) m_is[low] = 1'b0;
        case (m_state)
            0: if (p >= 0) begin
                m_state = 1;
                m_irq   = 1'b1;
                m_vec   = p;
            end
            1: if (p < 0) begin
                m_state = 0;
                m_irq   = 1'b0;
            end else if (cpu_ack) begin
                m_state     = 2;
                m_irq       = 1'b0;
                m_hand      = m_vec;
                m_is[m_vec] = 1'b1;
            end else begin
                m_vec = p;
            end
            default: begin
                m_state = 0;
                m_irq   = 1'b0;
            end
        endcase
    endtask

    task automatic step();
        logic any_is;
        @(posedge clk);
        model_edge();
        #1;
        any_is = 1'b0;
        for (int i = 0; i < N; i++) any_is = any_is | m_is[i];
        chk("irq", 32'(irq), 32'(m_irq));
        if (m_irq) chk("irq_vector", 32'(irq_vector), 32'(m_vec));
        chk("int_handled", 32'(int_handled), (m_hand < 0) ? 32'd0 : (32'd1 << m_hand));
        chk("busy", 32'(busy), 32'(any_is));
        if (m_hand >= 0) int_request[m_hand] = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        int_request = '0;
        int_mask    = '0;
        cpu_ack     = 1'b0;
        cpu_eoi     = 1'b0;
        m_state     = 0;
        m_irq       = 1'b0;
        m_vec       = 0;
        m_hand      = -1;
        for (int i = 0; i < N; i++) m_is[i] = 1'b0;
        step();
        step();
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_vec", 32'(irq_vector), 32'd0);
        chk("reset_handled", 32'(int_handled), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        int_request = 8'h20;
        step();
        chk("single_irq", 32'(irq), 32'd1);
        chk("single_vec", 32'(irq_vector), 32'd5);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        chk("single_handled", 32'(int_handled), 32'h20);
        chk("single_busy", 32'(busy), 32'd1);
        step();
        chk("single_pulse_width", 32'(int_handled), 32'd0);
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;
        chk("single_eoi_busy", 32'(busy), 32'd0);

        int_request = 8'h0C;
        step();
        chk("prio_vec2", 32'(irq_vector), 32'd2);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        chk("prio_handled2", 32'(int_handled), 32'h04);
        step();
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;
        step();
        chk("prio_irq3", 32'(irq), 32'd1);
        chk("prio_vec3", 32'(irq_vector), 32'd3);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        step();
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;

        int_request = 8'h10;
        step();
        int_mask = 8'h10;
        step();
        chk("mask_irq_drop", 32'(irq), 32'd0);
        step();
        chk("mask_no_pulse", 32'(int_handled), 32'd0);
        int_mask = 8'h00;
        step();
        chk("unmask_irq", 32'(irq), 32'd1);
        chk("unmask_vec", 32'(irq_vector), 32'd4);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        step();
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;

        int_request = 8'h40;
        step();
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        step();
        int_request = int_request | 8'h02;
        step();
`ifdef INT_CTRL_NESTING_EN
        chk("nest_irq", 32'(irq), 32'd1);
        chk("nest_vec", 32'(irq_vector), 32'd1);
        cpu_ack = 1'b1; cpu_eoi = 1'b1; step(); cpu_ack = 1'b0; cpu_eoi = 1'b0;
        chk("nest_ack_eoi_handled", 32'(int_handled), 32'h02);
        chk("nest_ack_eoi_busy", 32'(busy), 32'd1);
        step();
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;
        chk("nest_final_busy", 32'(busy), 32'd0);
`else
        chk("nonest_irq", 32'(irq), 32'd0);
        step();
        chk("nonest_irq_hold", 32'(irq), 32'd0);
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;
        step();
        chk("nonest_irq_after_eoi", 32'(irq), 32'd1);
        chk("nonest_vec", 32'(irq_vector), 32'd1);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        step();
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;
`endif

        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;
        chk("eoi_idle_busy", 32'(busy), 32'd0);
        chk("eoi_idle_irq", 32'(irq), 32'd0);

        int_request = 8'h08;
        step();
        chk("prereset_irq", 32'(irq), 32'd1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midreset_irq", 32'(irq), 32'd0);
        chk("midreset_vec", 32'(irq_vector), 32'd0);
        chk("midreset_handled", 32'(int_handled), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        step();
        chk("postreset_vec", 32'(irq_vector), 32'd3);
        cpu_ack = 1'b1; step(); cpu_ack = 1'b0;
        step();
        cpu_eoi = 1'b1; step(); cpu_eoi = 1'b0;

        for (int c = 0; c < 800; c++) begin
            int_request = int_request | N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) int_mask = N'($urandom & $urandom);
            cpu_ack = 1'($urandom_range(0, 1));
            cpu_eoi = ($urandom_range(0, 5) == 0);
            rst_n   = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
